// File: rtl/counter_poller_if.sv
// Handshake bundle between the counter poller and the FIFO counter stage.
// The poller uses the master view and the counter stage or its model uses the slave view.
interface counter_poller_if;
  logic       start;
  logic       IDLE;
  logic       valid;
  logic [4:0] data_out;
  logic       req;
  logic [2:0] idx;
  logic [4:0] cnt0;
  logic [4:0] cnt1;
  logic [4:0] cnt2;
  logic [4:0] cnt3;
  logic [4:0] cnt4;
  logic [7:0] sum;
  logic       done;
  logic       err;

  modport master (
    input  start, IDLE, valid, data_out,
    output req, idx, cnt0, cnt1, cnt2, cnt3, cnt4, sum, done, err
  );

  modport slave (
    output start, IDLE, valid, data_out,
    input  req, idx, cnt0, cnt1, cnt2, cnt3, cnt4, sum, done, err
  );
endinterface

// File: rtl/counter_poller.sv
// Polls the five FIFO pop counters in turn and latches each count plus their total.
// A round only runs while the datapath reports IDLE; losing IDLE mid-round aborts it.
module counter_poller #(
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset_L,
  counter_poller_if.master bus
);

  typedef enum logic [1:0] {WAIT_START, REQ_WAIT, GAP, FINISH} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
  localparam logic [2:0] IDX_LAST   = 3'd4;

  state_t     state_q, state_d;
  logic       pending_q;
  logic [2:0] idx_q;
  logic [4:0] cnt_q [5];
  logic [7:0] sum_q;
  logic [7:0] timer_q;
  logic       err_q;
  logic       begin_round, capture, time_out, abort;

  // Abort outranks a response, and a response outranks a timeout in the same cycle.
  always_comb begin
    state_d     = state_q;
    begin_round = 1'b0;
    capture     = 1'b0;
    time_out    = 1'b0;
    abort       = 1'b0;
    case (state_q)
      WAIT_START: begin
        if ((pending_q || bus.start) && bus.IDLE) begin
          begin_round = 1'b1;
          state_d     = REQ_WAIT;
        end
      end
      REQ_WAIT: begin
        if (!bus.IDLE) begin
          abort   = 1'b1;
          state_d = FINISH;
        end else if (bus.valid) begin
          capture = 1'b1;
          state_d = GAP;
        end else if (timer_q == TIMER_LAST) begin
          time_out = 1'b1;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (!bus.IDLE) begin
          abort   = 1'b1;
          state_d = FINISH;
        end else if (idx_q == IDX_LAST) begin
          state_d = FINISH;
        end else begin
          state_d = REQ_WAIT;
        end
      end
      FINISH:  state_d = WAIT_START;
      default: state_d = WAIT_START;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= WAIT_START;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pending_q <= 1'b0;
      idx_q     <= 3'd0;
      sum_q     <= 8'd0;
      timer_q   <= 8'd0;
      err_q     <= 1'b0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= 5'd0;
    end else begin
      if (state_q == WAIT_START) begin
        if (begin_round) begin
          pending_q <= 1'b0;
          sum_q     <= 8'd0;
          err_q     <= 1'b0;
          idx_q     <= 3'd0;
        end else if (bus.start) begin
          pending_q <= 1'b1;
        end
      end
      if (capture) sum_q <= sum_q + {3'b000, bus.data_out};
      if (capture || time_out) begin
        for (int i = 0; i < 5; i++) begin
          if (idx_q == 3'(i)) cnt_q[i] <= capture ? bus.data_out : 5'd0;
        end
      end
      if (abort || time_out) err_q <= 1'b1;
      if (state_q == REQ_WAIT && !capture && !time_out && !abort) timer_q <= timer_q + 8'd1;
      else                                                          timer_q <= 8'd0;
      if (state_q == GAP && !abort && idx_q != IDX_LAST) idx_q <= idx_q + 3'd1;
      if (state_q == FINISH) idx_q <= 3'd0;
    end
  end

  assign bus.req  = (state_q == REQ_WAIT);
  assign bus.done = (state_q == FINISH);
  assign bus.idx  = idx_q;
  assign bus.cnt0 = cnt_q[0];
  assign bus.cnt1 = cnt_q[1];
  assign bus.cnt2 = cnt_q[2];
  assign bus.cnt3 = cnt_q[3];
  assign bus.cnt4 = cnt_q[4];
  assign bus.sum  = sum_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_counter_poller.sv
// Directed bench for counter_poller: a counter-stage model answers requests, and a scoreboard
// of expected round results is filled when a round is launched and drained on each done pulse.
module tb_counter_poller;

  typedef struct packed {
    logic [4:0][4:0] cnt;
    logic [7:0]      sum;
    logic            err;
  } exp_t;

  logic clk;
  logic reset_L;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  logic [4:0][4:0] prev_cnt = '0;

  logic [4:0] resp_count [5];
  int         silent_idx = -1;
  int         req_len [5];
  int         done_count = 0;
  int         done_wide  = 0;
  int         rise_count = 0;
  int         gap_bad    = 0;
  int         proto_err  = 0;

  int cycles;
  int rise_snap;
  int done_snap;
  bit found;

  counter_poller_if bus();

  counter_poller #(.TIMEOUT(15)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0][4:0] counts, input int silent, input int abort_idx);
    exp_t e;
    e.sum = 8'd0;
    e.err = (silent >= 0) || (abort_idx >= 0);
    for (int i = 0; i < 5; i++) begin
      if (abort_idx >= 0 && i >= abort_idx) e.cnt[i] = prev_cnt[i];
      else if (i == silent)                  e.cnt[i] = 5'd0;
      else begin
        e.cnt[i] = counts[i];
        e.sum    = e.sum + {3'b000, counts[i]};
      end
    end
    sb_q.push_back(e);
    for (int i = 0; i < 5; i++) resp_count[i] = counts[i];
    silent_idx = silent;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget, output int waited);
    waited = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      waited++;
      if (bus.done === 1'b1) break;
    end
    checkOutput({tag, "_done"}, 32'(bus.done), 1);
  endtask

  task automatic checkRound(input string tag);
    exp_t e;
    checkOutput({tag, "_sb_entry"}, 32'(sb_q.size() > 0), 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    checkOutput({tag, "_cnt0"}, 32'(bus.cnt0), 32'(e.cnt[0]));
    checkOutput({tag, "_cnt1"}, 32'(bus.cnt1), 32'(e.cnt[1]));
    checkOutput({tag, "_cnt2"}, 32'(bus.cnt2), 32'(e.cnt[2]));
    checkOutput({tag, "_cnt3"}, 32'(bus.cnt3), 32'(e.cnt[3]));
    checkOutput({tag, "_cnt4"}, 32'(bus.cnt4), 32'(e.cnt[4]));
    checkOutput({tag, "_sum"},  32'(bus.sum),  32'(e.sum));
    checkOutput({tag, "_err"},  32'(bus.err),  32'(e.err));
    prev_cnt = e.cnt;
  endtask

  // Counter-stage model plus protocol monitor: answers on the second cycle of each request.
  initial begin
    bit req_prev  = 1'b0;
    bit done_prev = 1'b0;
    bit in_round  = 1'b0;
    int high_run  = 0;
    int low_run   = 0;
    int cur_idx   = 0;
    bus.valid    = 1'b0;
    bus.data_out = 5'd0;
    for (int i = 0; i < 5; i++) req_len[i] = 0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_count++;
        if (done_prev) done_wide++;
      end
      done_prev = (bus.done === 1'b1);
      if (bus.idx > 3'd4) proto_err++;
      if (bus.req === 1'b1) begin
        if (!req_prev) begin
          rise_count++;
          if (in_round && low_run != 1) gap_bad++;
          in_round = 1'b1;
          cur_idx  = int'(bus.idx);
          high_run = 0;
        end
        if (int'(bus.idx) != cur_idx) proto_err++;
        high_run++;
        low_run      = 0;
        bus.valid    = (high_run == 2) && (cur_idx != silent_idx) && (cur_idx < 5);
        bus.data_out = bus.valid ? resp_count[cur_idx] : 5'd0;
      end else begin
        if (req_prev && cur_idx < 5) req_len[cur_idx] = high_run;
        low_run++;
        bus.valid    = 1'b0;
        bus.data_out = 5'd0;
      end
      if (bus.done === 1'b1) in_round = 1'b0;
      req_prev = (bus.req === 1'b1);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_L   = 1'b0;
    bus.start = 1'b0;
    bus.IDLE  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_req",  32'(bus.req),  0);
    checkOutput("rst_idx",  32'(bus.idx),  0);
    checkOutput("rst_done", 32'(bus.done), 0);
    checkOutput("rst_err",  32'(bus.err),  0);
    checkOutput("rst_sum",  32'(bus.sum),  0);
    checkOutput("rst_cnt0", 32'(bus.cnt0), 0);
    checkOutput("rst_cnt4", 32'(bus.cnt4), 0);
    bus.IDLE = 1'b1;
    reset_L  = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_req", 32'(bus.req), 0);

    // Normal round with distinct counts.
    rise_snap = rise_count;
    applyStimulus({5'd11, 5'd9, 5'd7, 5'd5, 5'd3}, -1, -1);
    checkOutput("a_req", 32'(bus.req), 1);
    checkOutput("a_idx", 32'(bus.idx), 0);
    waitDone("a", 100, cycles);
    checkOutput("a_latency", 32'(cycles), 15);
    checkRound("a");
    @(negedge clk);
    checkOutput("a_done_pulse", 32'(bus.done), 0);
    #1;
    checkOutput("a_rises", 32'(rise_count - rise_snap), 5);
    checkOutput("a_gaps", 32'(gap_bad), 0);

    // Every counter at its maximum.
    applyStimulus({5{5'd31}}, -1, -1);
    waitDone("b", 100, cycles);
    checkRound("b");
    repeat (10) @(negedge clk);
    checkOutput("b_sum_hold", 32'(bus.sum), 155);

    // Index 2 never answers.
    applyStimulus({5'd6, 5'd4, 5'd17, 5'd2, 5'd1}, 2, -1);
    waitDone("c", 100, cycles);
    checkOutput("c_latency", 32'(cycles), 28);
    checkRound("c");
    repeat (5) @(negedge clk);
    #1;
    checkOutput("c_req_len2", 32'(req_len[2]), 15);
    checkOutput("c_req_len1", 32'(req_len[1]), 2);
    checkOutput("c_err_hold", 32'(bus.err), 1);

    // IDLE drops on idx 1 in the same cycle the response arrives.
    rise_snap = rise_count;
    applyStimulus({5'd15, 5'd25, 5'd30, 5'd20, 5'd10}, -1, 1);
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.req === 1'b1 && bus.idx == 3'd1) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("d_reach_idx1", 32'(found), 1);
    @(negedge clk);
    bus.IDLE = 1'b0;
    waitDone("d", 5, cycles);
    checkOutput("d_abort_latency", 32'(cycles), 1);
    checkOutput("d_req_low", 32'(bus.req), 0);
    checkRound("d");
    bus.IDLE = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("d_rises", 32'(rise_count - rise_snap), 2);

    // Start held pending until IDLE returns; a second start mid-round is ignored.
    bus.IDLE  = 1'b0;
    rise_snap = rise_count;
    done_snap = done_count;
    applyStimulus({5'd8, 5'd16, 5'd1, 5'd31, 5'd0}, -1, -1);
    checkOutput("e_pending_req", 32'(bus.req), 0);
    repeat (9) @(negedge clk);
    bus.IDLE = 1'b1;
    @(negedge clk);
    checkOutput("e_req", 32'(bus.req), 1);
    checkOutput("e_idx", 32'(bus.idx), 0);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone("e", 100, cycles);
    checkRound("e");
    repeat (20) @(negedge clk);
    #1;
    checkOutput("e_one_done", 32'(done_count - done_snap), 1);
    checkOutput("e_rises", 32'(rise_count - rise_snap), 5);

    // Reset between edges in the middle of a round.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.req === 1'b1 && bus.idx == 3'd2) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("f_reach_idx2", 32'(found), 1);
    #2 reset_L = 1'b0;
    #1;
    checkOutput("f_req",  32'(bus.req),  0);
    checkOutput("f_idx",  32'(bus.idx),  0);
    checkOutput("f_done", 32'(bus.done), 0);
    checkOutput("f_sum",  32'(bus.sum),  0);
    checkOutput("f_cnt1", 32'(bus.cnt1), 0);
    checkOutput("f_cnt3", 32'(bus.cnt3), 0);
    done_snap = done_count;
    rise_snap = rise_count;
    @(negedge clk);
    reset_L = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    checkOutput("f_no_done", 32'(done_count - done_snap), 0);
    checkOutput("f_no_req",  32'(rise_count - rise_snap), 0);
    checkOutput("f_cnt2",    32'(bus.cnt2), 0);

    checkOutput("gap_spacing", 32'(gap_bad),   0);
    checkOutput("protocol",    32'(proto_err), 0);
    checkOutput("done_width",  32'(done_wide), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
